mul_div_issuer: RTL and testbench

Initiator side of the multi-cycle multiply/divide handshake. It sits between the EX stage and the shift-add/shift-subtract `multDiv` engine. It captures an RV32M request, converts signed operands to magnitudes and pulses the engine's valid. It then stalls the pipeline until ready, sign-corrects the 64-bit engine output and returns the 32-bit architectural result. Divide-by-zero and signed overflow are resolved locally without engine use.

---
 rtl/mul_div_issuer.sv | 141 ++++++++++++++
 tb/tb_mul_div_issuer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_issuer.sv
// Issuer for the multi-cycle RV32M multiply/divide engine: captures the EX request,
// hands operand magnitudes to the engine, stalls until ready and sign-corrects the result.
module mul_div_issuer #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              kill,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic              md_valid,
    output logic              md_mode,
    output logic [XLEN-1:0]   md_in_A,
    output logic [XLEN-1:0]   md_in_B,
    input  logic              md_ready,
    input  logic [2*XLEN-1:0] md_out
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, DRAIN, DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state;
    op_e             op;
    logic            sign1;
    logic            sign2;

    logic            capture;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] corrected;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // A request is taken from IDLE, or straight out of DRAIN when the flushed op's
    // result arrives, so a younger instruction issues without an extra idle cycle.
    assign capture = req && !kill && (state == IDLE || (state == DRAIN && md_ready));

    assign stall = req && !kill && (state != DONE);
    assign done  = (state == DONE) && !kill;

    assign neg1 = (funct3 == OP_MULH || funct3 == OP_MULHSU || funct3 == OP_DIV || funct3 == OP_REM)
                  && rs1[XLEN-1];
    assign neg2 = (funct3 == OP_MULH || funct3 == OP_DIV || funct3 == OP_REM) && rs2[XLEN-1];
    assign mag1 = neg1 ? -rs1 : rs1;
    assign mag2 = neg2 ? -rs2 : rs2;

    assign div_zero    = funct3[2] && (rs2 == '0);
    assign div_ovf     = (funct3 == OP_DIV || funct3 == OP_REM) && rs1 == INT_MIN && rs2 == '1;
    assign fast_result = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : INT_MIN);

    assign quo = md_out[XLEN-1:0];
    assign rem = md_out[2*XLEN-1:XLEN];

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        prod = md_out;
        if ((op == OP_MULH && (sign1 ^ sign2)) || (op == OP_MULHSU && sign1))
            prod = -md_out;
        corrected = quo;
        case (op)
            OP_MUL:                         corrected = md_out[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   corrected = prod[2*XLEN-1:XLEN];
            OP_DIV:                         corrected = (sign1 ^ sign2) ? -quo : quo;
            OP_DIVU:                        corrected = quo;
            OP_REM:                         corrected = sign1 ? -rem : rem;
            OP_REMU:                        corrected = rem;
            default:                        corrected = quo;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= OP_MUL;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result   <= '0;
            md_valid <= 1'b0;
            md_mode  <= 1'b0;
            md_in_A  <= '0;
            md_in_B  <= '0;
        end else begin
            md_valid <= 1'b0;
            if (capture) begin
                op      <= op_e'(funct3);
                sign1   <= neg1;
                sign2   <= neg2;
                md_mode <= funct3[2];
                if (div_zero || div_ovf) begin
                    result <= fast_result;
                    state  <= DONE;
                end else begin
                    md_in_A  <= mag1;
                    md_in_B  <= mag2;
                    md_valid <= 1'b1;
                    state    <= ISSUE;
                end
            end else begin
                case (state)
                    IDLE:  state <= IDLE;
                    ISSUE: state <= kill ? DRAIN : WAIT;
                    WAIT: begin
                        if (md_ready) begin
                            if (kill) begin
                                state <= IDLE;
                            end else begin
                                result <= corrected;
                                state  <= DONE;
                            end
                        end else if (kill) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: if (md_ready) state <= IDLE;
                    DONE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_issuer.sv
// Directed bench for mul_div_issuer with a behavioural 33-cycle multDiv engine model.
module tb_mul_div_issuer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_A;
    logic [31:0] md_in_B;
    logic        md_ready;
    logic [63:0] md_out;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_issuer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .kill     (kill),
        .funct3   (funct3),
        .rs1      (rs1),
        .rs2      (rs2),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .md_valid (md_valid),
        .md_mode  (md_mode),
        .md_in_A  (md_in_A),
        .md_in_B  (md_in_B),
        .md_ready (md_ready),
        .md_out   (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: md_ready one cycle, 33 cycles after the md_valid cycle; aborts on reset.
    logic        eng_busy;
    logic        eng_mode;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    int          eng_cnt;

    initial begin
        md_ready = 1'b0;
        md_out   = '0;
        eng_busy = 1'b0;
        eng_mode = 1'b0;
        eng_a    = '0;
        eng_b    = '0;
        eng_cnt  = 0;
        forever begin
            @(negedge clk);
            md_ready = 1'b0;
            if (!rst_n) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_busy = 1'b0;
                    md_ready = 1'b1;
                    if (eng_mode)
                        md_out = (eng_b == 0) ? 64'h0 : {eng_a % eng_b, eng_a / eng_b};
                    else
                        md_out = {32'h0, eng_a} * {32'h0, eng_b};
                end
            end else if (md_valid) begin
                eng_busy = 1'b1;
                eng_cnt  = 33;
                eng_mode = md_mode;
                eng_a    = md_in_A;
                eng_b    = md_in_B;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one op at cycle N (k=0) and tracks stall/md_valid/done until done or budget.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int stall_n;
        int valid_n;
        int valid_at;
        int done_at;
        stall_n  = 0;
        valid_n  = 0;
        valid_at = -1;
        done_at  = -1;
        @(negedge clk);
        req    = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        for (int k = 0; k < 80 && done_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (stall) stall_n++;
            if (md_valid) begin
                valid_n++;
                if (valid_at < 0) valid_at = k;
            end
            if (done) done_at = k;
            if (!stall) req = 1'b0;
        end
        check({tag, " done_cycle"}, done_at, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " stall_cycles"}, stall_n, exp_lat);
        check({tag, " md_valid_count"}, valid_n, (exp_lat > 1) ? 1 : 0);
        check({tag, " md_valid_cycle"}, valid_at, (exp_lat > 1) ? 1 : -1);
        @(negedge clk);
        #1;
        check({tag, " done_pulse_ends"}, done, 1'b0);
    endtask

    int kill_done_n;
    int kill_stall_n;
    int kill_valid_at;
    int kill_done_at;

    initial begin
        rst_n  = 1'b0;
        req    = 1'b0;
        kill   = 1'b0;
        funct3 = 3'd0;
        rs1    = '0;
        rs2    = '0;
        #1;
        check("reset stall", stall, 1'b0);
        check("reset done", done, 1'b0);
        check("reset md_valid", md_valid, 1'b0);
        check("reset md_mode", md_mode, 1'b0);
        check("reset result", result, 32'h0);
        check("reset md_in_A", md_in_A, 32'h0);
        check("reset md_in_B", md_in_B, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        do_op("MULH",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
        do_op("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35);
        do_op("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        do_op("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
        do_op("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
        do_op("DIVU",   3'd5, 32'd7,          32'd2,         32'd3,         35);
        do_op("REMU",   3'd7, 32'd7,          32'd2,         32'd1,         35);
        do_op("REM_NEG_DIVISOR", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1,         35);
        do_op("DIV_BY_ZERO",  3'd4, 32'd5,    32'd0,         32'hFFFF_FFFF, 1);
        do_op("REMU_BY_ZERO", 3'd7, 32'd5,    32'd0,         32'd5,         1);
        do_op("DIV_OVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM_OVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush during WAIT; a younger DIVU waits out the drain, then issues directly.
        kill_done_n   = 0;
        kill_stall_n  = 0;
        kill_valid_at = -1;
        kill_done_at  = -1;
        @(negedge clk);
        req    = 1'b1;
        funct3 = 3'd0;
        rs1    = 32'd5;
        rs2    = 32'd6;
        for (int k = 0; k < 100 && kill_done_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 10) kill = 1'b1;
            if (k == 11) begin
                kill = 1'b0;
                req  = 1'b0;
            end
            if (k == 12) begin
                req    = 1'b1;
                funct3 = 3'd5;
                rs1    = 32'd100;
                rs2    = 32'd7;
            end
            #1;
            if (k == 10) check("KILL stall_drops", stall, 1'b0);
            if (k == 11) check("KILL drain_no_stall", stall, 1'b0);
            if (k >= 12 && stall) kill_stall_n++;
            if (md_valid && k > 1 && kill_valid_at < 0) kill_valid_at = k;
            if (done) begin
                kill_done_n++;
                kill_done_at = k;
            end
            if (k >= 12 && !stall) req = 1'b0;
        end
        check("KILL reissue_cycle", kill_valid_at, 35);
        check("KILL done_cycle", kill_done_at, 69);
        check("KILL result", result, 32'd14);
        check("KILL done_count", kill_done_n, 1);
        check("KILL stall_cycles", kill_stall_n, 57);

        // Reset mid-operation, then a fresh multiply.
        @(negedge clk);
        req    = 1'b1;
        funct3 = 3'd4;
        rs1    = 32'd50;
        rs2    = 32'd3;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("RST stall", stall, 1'b0);
        check("RST done", done, 1'b0);
        check("RST md_valid", md_valid, 1'b0);
        check("RST md_mode", md_mode, 1'b0);
        check("RST result", result, 32'h0);
        check("RST md_in_A", md_in_A, 32'h0);
        check("RST md_in_B", md_in_B, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("MUL_AFTER_RST", 3'd0, 32'd3, 32'd4, 32'd12, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
